// File: rtl/fmap_uart_loader_if.sv
// Host-side loader bus: UART rx/tx bytes, fmap_bank write port, core start/done.
// Latency: n/a (signal bundle only).
// Backpressure: transmit side uses tdata_req/tdata_ready; rx and fbank sides have none.
interface fmap_uart_loader_if;
    logic [7:0]  rdata;
    logic        rdata_valid;
    logic [7:0]  tdata;
    logic        tdata_req;
    logic        tdata_ready;
    logic [14:0] fbank_waddr;
    logic [7:0]  fdata_w;
    logic        fbank_wen;
    logic        init;
    logic        done;
    logic [3:0]  label;
    logic        busy;

    // Loader side: drives transmit, fbank write and core start
    modport master (
        input  rdata, rdata_valid, tdata_ready, done, label,
        output tdata, tdata_req, fbank_waddr, fdata_w, fbank_wen, init, busy
    );

    // Environment side: UART, fmap_bank and core
    modport slave (
        output rdata, rdata_valid, tdata_ready, done, label,
        input  tdata, tdata_req, fbank_waddr, fdata_w, fbank_wen, init, busy
    );
endinterface

// File: rtl/fmap_uart_loader.sv
// Receives one framed image from the UART, writes it to fmap_bank, checks XOR sum, runs core, returns label.
// Latency: fbank write 1 cycle after each rx strobe; init 2 cycles after checksum; tdata_req 1 cycle after done.
// Backpressure: tdata held with tdata_req until tdata_ready; rx bytes outside LOAD/CHECK/IDLE-header are dropped.
module fmap_uart_loader #(
    parameter int         IMG_BYTES = 784,
    parameter logic [7:0] HDR       = 8'hA5,
    parameter int         TIMEOUT   = 1_000_000,
    parameter logic [7:0] ERR_CODE  = 8'h45
) (
    input  logic                clk,
    input  logic                rst,
    fmap_uart_loader_if.master  bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_CHECK, S_RUN, S_WAIT, S_SEND
    } state_t;

    // Idle counter only needs to reach TIMEOUT-1; the hit cycle itself leaves the state.
    localparam int                TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [14:0]       LAST     = 15'(IMG_BYTES - 1);
    localparam logic [TW-1:0]     TMO_LAST = TW'(TIMEOUT - 1);

    state_t        r_state, w_state_nxt;
    logic [14:0]   r_count;
    logic [7:0]    r_acc;
    logic [TW-1:0] r_tmo;
    logic [7:0]    r_tdata;
    logic [14:0]   r_waddr;
    logic [7:0]    r_wdata;
    logic          r_wen;
    logic          r_init;

    logic          w_start;
    logic          w_write;
    logic          w_tmo_inc;
    logic          w_err;
    logic          w_lbl;
    logic          w_fire_init;
    logic          w_req;
    logic          w_busy;
    logic          w_tmo_hit;

    assign w_tmo_hit = (r_tmo == TMO_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state and control decode
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_write     = 1'b0;
        w_tmo_inc   = 1'b0;
        w_err       = 1'b0;
        w_lbl       = 1'b0;
        w_fire_init = 1'b0;
        w_req       = (r_state == S_SEND);
        w_busy      = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                if (bus.rdata_valid && (bus.rdata == HDR)) begin
                    w_start     = 1'b1;
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                if (bus.rdata_valid) begin
                    w_write = 1'b1;
                    if (r_count == LAST) w_state_nxt = S_CHECK;
                end else if (w_tmo_hit) begin
                    w_err       = 1'b1;
                    w_state_nxt = S_SEND;
                end else begin
                    w_tmo_inc = 1'b1;
                end
            end
            S_CHECK: begin
                if (bus.rdata_valid) begin
                    if (bus.rdata == r_acc) begin
                        w_state_nxt = S_RUN;
                    end else begin
                        w_err       = 1'b1;
                        w_state_nxt = S_SEND;
                    end
                end else if (w_tmo_hit) begin
                    w_err       = 1'b1;
                    w_state_nxt = S_SEND;
                end else begin
                    w_tmo_inc = 1'b1;
                end
            end
            S_RUN: begin
                w_fire_init = 1'b1;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (bus.done) begin
                    w_lbl       = 1'b1;
                    w_state_nxt = S_SEND;
                end
            end
            S_SEND: begin
                if (bus.tdata_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath: address/checksum/idle counters, registered write port, init pulse, tx byte
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
            r_acc   <= '0;
            r_tmo   <= '0;
            r_tdata <= '0;
            r_waddr <= '0;
            r_wdata <= '0;
            r_wen   <= 1'b0;
            r_init  <= 1'b0;
        end else begin
            r_wen  <= w_write;
            r_init <= w_fire_init;
            if (w_start) begin
                r_count <= '0;
                r_acc   <= '0;
            end else if (w_write) begin
                r_waddr <= r_count;
                r_wdata <= bus.rdata;
                r_acc   <= r_acc ^ bus.rdata;
                // Last address exits to CHECK instead of counting, so the counter never wraps
                if (r_count != LAST) r_count <= r_count + 15'd1;
            end
            if (w_start || bus.rdata_valid) r_tmo <= '0;
            else if (w_tmo_inc)             r_tmo <= r_tmo + 1'b1;
            if (w_err)      r_tdata <= ERR_CODE;
            else if (w_lbl) r_tdata <= 8'h30 + {4'h0, bus.label};
        end
    end

    assign bus.tdata       = r_tdata;
    assign bus.tdata_req   = w_req;
    assign bus.fbank_waddr = r_waddr;
    assign bus.fdata_w     = r_wdata;
    assign bus.fbank_wen   = r_wen;
    assign bus.init        = r_init;
    assign bus.busy        = w_busy;
endmodule
